// File: rtl/multi_ball_box.sv
// multi_ball_box: N_BALLS 8x8 sprites bouncing in a walled box, walls flash on hit.
// Define BALL_COLLIDE_EN to make overlapping balls reverse before stepping.
module multi_ball_box #(
  parameter int N_BALLS      = 4,
  parameter int PIX_W        = 12,
  parameter int BOX_XL       = 187,
  parameter int BOX_XR       = 452,
  parameter int BOX_YT       = 107,
  parameter int BOX_YB       = 372,
  parameter int WALL_W       = 6,
  parameter int FLASH_FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             video_on,
  input  logic [PIX_W-1:0] pixel_x,
  input  logic [PIX_W-1:0] pixel_y,
  input  logic             frame_tick,
  input  logic             speed_up,
  input  logic             speed_dn,
  input  logic             place,
  output logic [2:0]       rgb,
  output logic             busy
);
  localparam int KW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  localparam logic [PIX_W-1:0] BXL = PIX_W'(BOX_XL);
  localparam logic [PIX_W-1:0] BXR = PIX_W'(BOX_XR);
  localparam logic [PIX_W-1:0] BYT = PIX_W'(BOX_YT);
  localparam logic [PIX_W-1:0] BYB = PIX_W'(BOX_YB);
  localparam logic [PIX_W-1:0] X_MIN = PIX_W'(BOX_XL + WALL_W);
  localparam logic [PIX_W-1:0] X_MAX = PIX_W'(BOX_XR - WALL_W - 7);
  localparam logic [PIX_W-1:0] Y_MIN = PIX_W'(BOX_YT + WALL_W);
  localparam logic [PIX_W-1:0] Y_MAX = PIX_W'(BOX_YB - WALL_W - 7);
  localparam logic [PIX_W-1:0] X_LO = PIX_W'(BOX_XL + WALL_W - 1);
  localparam logic [PIX_W-1:0] Y_LO = PIX_W'(BOX_YT + WALL_W - 1);
  localparam logic [PIX_W-1:0] WR_X = PIX_W'(BOX_XR - WALL_W);
  localparam logic [PIX_W-1:0] WB_Y = PIX_W'(BOX_YB - WALL_W);
  localparam logic [FW-1:0] FL_LD = FW'(FLASH_FRAMES);

  typedef enum logic [1:0] {IDLE, UPD, DONE} state_t;

  state_t             state;
  logic [KW-1:0]      k;
  logic [1:0]         lvl;
  logic [PIX_W-1:0]   bx [N_BALLS];
  logic [PIX_W-1:0]   by [N_BALLS];
  logic [N_BALLS-1:0] bdx;
  logic [N_BALLS-1:0] bdy;
  logic [FW-1:0]      fl_l, fl_r, fl_t, fl_b;
  logic [PIX_W-1:0]   s;

  assign s = PIX_W'(1) << lvl;

  function automatic logic [PIX_W-1:0] clamp(
    input logic [PIX_W-1:0] v,
    input logic [PIX_W-1:0] lo,
    input logic [PIX_W-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [7:0] sprite(input logic [2:0] r);
    case (r)
      3'd0, 3'd7: return 8'h18;
      3'd1, 3'd6: return 8'h3C;
      3'd2, 3'd5: return 8'h7E;
      default:    return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] wcol(input logic [FW-1:0] c);
    return (c != '0) ? 3'b001 : 3'b010;
  endfunction

`ifdef BALL_COLLIDE_EN
  function automatic logic near(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b
  );
    logic [PIX_W-1:0] d;
    d = (a > b) ? a - b : b - a;
    return d < PIX_W'(8);
  endfunction
`endif

  logic [PIX_W-1:0] cx, cy, nx, ny;
  logic             cdx, cdy, ndx, ndy;
  logic             hit_l, hit_r, hit_t, hit_b;

  always_comb begin
    cx  = bx[k];
    cy  = by[k];
    cdx = bdx[k];
    cdy = bdy[k];
`ifdef BALL_COLLIDE_EN
    for (int j = 0; j < N_BALLS; j++) begin
      if (KW'(j) != k && near(bx[k], bx[j]) &&
          near(by[k], by[j])) begin
        cdx = ~bdx[k];
        cdy = ~bdy[k];
      end
    end
`endif
    // wall checks only apply toward the wall the ball is heading for
    hit_l = !cdx && (cx <= X_LO + s);
    hit_r = cdx && (cx + s > X_MAX);
    hit_t = !cdy && (cy <= Y_LO + s);
    hit_b = cdy && (cy + s > Y_MAX);
    nx  = hit_l ? X_MIN : hit_r ? X_MAX :
          cdx ? cx + s : cx - s;
    ny  = hit_t ? Y_MIN : hit_b ? Y_MAX :
          cdy ? cy + s : cy - s;
    ndx = hit_l | (cdx & ~hit_r);
    ndy = hit_t | (cdy & ~hit_b);
  end

  logic             in_box;
  logic [2:0]       pix;
  logic [PIX_W-1:0] row, col;
  logic [7:0]       line;

  assign in_box = pixel_x >= BXL && pixel_x <= BXR &&
                  pixel_y >= BYT && pixel_y <= BYB;

  always_comb begin
    pix  = 3'b111;
    row  = '0;
    col  = '0;
    line = '0;
    if (in_box) begin
      if (pixel_x < X_MIN)      pix = wcol(fl_l);
      else if (pixel_x > WR_X)  pix = wcol(fl_r);
      else if (pixel_y < Y_MIN) pix = wcol(fl_t);
      else if (pixel_y > WB_Y)  pix = wcol(fl_b);
      else                      pix = 3'b110;
    end
    // descending scan so the lowest index ends up on top
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      row  = pixel_y - by[i];
      col  = pixel_x - bx[i];
      line = sprite(row[2:0]);
      if (row < PIX_W'(8) && col < PIX_W'(8) && line[col[2:0]])
        pix = {1'b1, 2'(i)};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rgb <= '0;
    else          rgb <= video_on ? pix : 3'b000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      k     <= '0;
      lvl   <= '0;
      fl_l  <= '0;
      fl_r  <= '0;
      fl_t  <= '0;
      fl_b  <= '0;
      for (int i = 0; i < N_BALLS; i++) begin
        bx[i]  <= PIX_W'(BOX_XL + WALL_W + 4 + 16 * i);
        by[i]  <= PIX_W'(BOX_YT + WALL_W + 4 + 8 * i);
        bdx[i] <= 1'(i % 2);
        bdy[i] <= 1'b1;
      end
    end else begin
      unique case (1'b1)
        speed_up && !speed_dn && lvl != 2'd3:
          lvl <= lvl + 2'd1;
        speed_dn && !speed_up && lvl != 2'd0:
          lvl <= lvl - 2'd1;
        default: ;
      endcase
      unique case (state)
        IDLE: begin
          if (place) begin
            bx[0] <= clamp(pixel_x, X_MIN, X_MAX);
            by[0] <= clamp(pixel_y, Y_MIN, Y_MAX);
          end else if (frame_tick) begin
            state <= UPD;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        UPD: begin
          bx[k]  <= nx;
          by[k]  <= ny;
          bdx[k] <= ndx;
          bdy[k] <= ndy;
          if (hit_l) fl_l <= FL_LD;
          if (hit_r) fl_r <= FL_LD;
          if (hit_t) fl_t <= FL_LD;
          if (hit_b) fl_b <= FL_LD;
          if (k == KW'(N_BALLS - 1)) state <= DONE;
          else                       k <= k + 1'b1;
        end
        DONE: begin
          if (fl_l != '0) fl_l <= fl_l - 1'b1;
          if (fl_r != '0) fl_r <= fl_r - 1'b1;
          if (fl_t != '0) fl_t <= fl_t - 1'b1;
          if (fl_b != '0) fl_b <= fl_b - 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_ball_box.sv
// tb_multi_ball_box: directed render-probe checks of ball motion, walls, speed, place.
// Ball positions are observed through rgb using row 3 (solid) of the sprite.
module tb_multi_ball_box;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        video_on;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic        frame_tick;
  logic        speed_up;
  logic        speed_dn;
  logic        place;
  logic [2:0]  rgb;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  multi_ball_box dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_tick (frame_tick),
    .speed_up   (speed_up),
    .speed_dn   (speed_dn),
    .place      (place),
    .rgb        (rgb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_pix(
    input string    tag,
    input int       x,
    input int       y,
    input logic [2:0] exp
  );
    @(negedge clk);
    pixel_x = 12'(x);
    pixel_y = 12'(y);
    @(posedge clk);
    #1;
    check(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic chk_ball(
    input string      tag,
    input int         x,
    input int         y,
    input logic [2:0] c,
    input logic [2:0] left_nbr
  );
    chk_pix({tag, "/r3l"}, x, y + 3, c);
    chk_pix({tag, "/r3r"}, x + 7, y + 3, c);
    chk_pix({tag, "/lft"}, x - 1, y + 3, left_nbr);
    chk_pix({tag, "/top"}, x + 3, y - 1, 3'b110);
  endtask

  task automatic frame(input bit dbl, output int w);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    w = 0;
    while (busy && w < 20) begin
      w++;
      frame_tick = dbl && (w == 2);
      place      = dbl && (w == 2);
      if (dbl && w == 2) begin
        pixel_x = 12'd300;
        pixel_y = 12'd300;
      end
      @(negedge clk);
    end
    frame_tick = 1'b0;
    place      = 1'b0;
  endtask

  task automatic frames(input int n);
    int w;
    for (int i = 0; i < n; i++) frame(1'b0, w);
  endtask

  task automatic pulse(input bit up, input bit dn, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      speed_up = up;
      speed_dn = dn;
      @(negedge clk);
      speed_up = 1'b0;
      speed_dn = 1'b0;
    end
  endtask

  task automatic place_at(input int x, input int y, input bit tick);
    @(negedge clk);
    pixel_x    = 12'(x);
    pixel_y    = 12'(y);
    place      = 1'b1;
    frame_tick = tick;
    @(negedge clk);
    place      = 1'b0;
    frame_tick = 1'b0;
    check("place_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("place_busy2", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    reset_n    = 1'b0;
    video_on   = 1'b1;
    pixel_x    = 12'd200;
    pixel_y    = 12'd120;
    frame_tick = 1'b0;
    speed_up   = 1'b0;
    speed_dn   = 1'b0;
    place      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    chk_ball("rst_b0", 197, 117, 3'b100, 3'b110);
    chk_pix("rst_b1", 213, 128, 3'b101);
    chk_pix("interior", 300, 250, 3'b110);
    chk_pix("bg", 50, 50, 3'b111);
    chk_pix("lwall0", 189, 240, 3'b010);
    chk_pix("rwall0", 450, 240, 3'b010);
    chk_pix("twall0", 300, 109, 3'b010);
    @(negedge clk);
    video_on = 1'b0;
    chk_pix("vid_off", 200, 120, 3'b000);
    video_on = 1'b1;

    pulse(1'b1, 1'b1, 1);
    frame(1'b1, w);
    check("busy_w", 32'(w), 32'd5);
    repeat (3) @(negedge clk);
    check("no_requeue", 32'(busy), 32'd0);
    chk_ball("f1_b0", 196, 118, 3'b100, 3'b110);
    chk_ball("f1_b1", 214, 126, 3'b101, 3'b110);

    frames(1);
    pulse(1'b1, 1'b0, 5);
    frames(1);
    chk_ball("f3_b0", 193, 127, 3'b100, 3'b001);
    chk_ball("f3_b1", 223, 135, 3'b101, 3'b110);
    chk_pix("lwall_f3", 189, 240, 3'b001);
    chk_pix("twall_f3", 300, 109, 3'b010);

    pulse(1'b0, 1'b1, 4);
    frames(1);
    chk_ball("f4_b0", 194, 128, 3'b100, 3'b110);
    frames(5);
    chk_pix("lwall_f9", 189, 240, 3'b001);
    frames(1);
    chk_pix("lwall_f10", 189, 240, 3'b010);
    chk_ball("f10_b0", 200, 134, 3'b100, 3'b110);

    place_at(450, 300, 1'b1);
    chk_ball("plc_b0", 439, 300, 3'b100, 3'b110);
    chk_pix("rwall_pre", 450, 240, 3'b010);
    frames(1);
    chk_ball("f11_b0", 439, 301, 3'b100, 3'b110);
    chk_pix("rwall_f11", 450, 240, 3'b001);
    frames(1);
    chk_ball("f12_b0", 438, 302, 3'b100, 3'b110);

    place_at(236, 144, 1'b0);
    frames(1);
`ifdef BALL_COLLIDE_EN
    chk_ball("coll_b0", 237, 143, 3'b100, 3'b101);
`else
    chk_ball("coll_b0", 235, 145, 3'b100, 3'b101);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
